// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for decoder_2to4: cycles sel over the enabled mask positions
// at DIV clocks per position, with hold/single-step and a tick per advance.
module decoder_scan_ctrl #(
    parameter int DIV = 100000,
    parameter int CW  = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic       step,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       tick,
    output logic       active
);

    // state | meaning
    // IDLE  | not scanning, en forced low
    // RUN   | prescaler counts, sel advances every DIV cycles
    // HOLD  | prescaler frozen, sel advances once per step rising edge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          step_q;

    // Nearest enabled position after s going upward mod 4; s itself if none.
    function automatic logic [1:0] next_pos(input logic [1:0] s, input logic [3:0] m);
        logic [1:0] p;
        next_pos = s;
        for (int k = 3; k >= 1; k--) begin
            p = s + 2'(k);
            if (m[p]) next_pos = p;
        end
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start && (mask != 4'd0)) begin
                    state_d = RUN;
                    sel_d   = lowest_set(mask);
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (hold) begin
                    state_d = HOLD;
                end else if (presc_q == TC) begin
                    presc_d = '0;
                    sel_d   = next_pos(sel_q, mask);
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (!hold) begin
                    state_d = RUN;
                end else if (step && !step_q) begin
                    sel_d  = next_pos(sel_q, mask);
                    tick_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            step_q  <= step;
        end
    end

    assign sel    = sel_q;
    assign tick   = tick_q;
    assign active = (state_q != IDLE);
    assign en     = active & mask[sel_q];

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed and randomized checks of decoder_scan_ctrl (DIV=4) against a
// cycle-level reference model of the scan rules.
module tb_decoder_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, hold, step;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en, tick, active;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: mode 0=idle 1=run 2=hold
    int         m_mode = 0;
    int         m_sel  = 0;
    int         m_pc   = 0;
    bit         m_tick = 0;
    bit         m_stepq = 0;

    decoder_scan_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .hold(hold), .step(step), .mask(mask),
        .sel(sel), .en(en), .tick(tick), .active(active)
    );

    always #5 clk = ~clk;

    function automatic int scan_next(input int s, input logic [3:0] m);
        for (int k = 1; k <= 3; k++)
            if (m[(s + k) % 4]) return (s + k) % 4;
        return s;
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_mode = 0; m_sel = 0; m_pc = 0; m_tick = 0; m_stepq = 0;
        end else begin
            m_tick = 0;
            if (stop) begin
                if (m_mode != 0) m_pc = 0;
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (start && mask != 0) begin
                    m_mode = 1; m_sel = lowest(mask); m_pc = 0;
                end
            end else if (m_mode == 1) begin
                if (hold) m_mode = 2;
                else if (m_pc == DIV - 1) begin
                    m_pc = 0; m_sel = scan_next(m_sel, mask); m_tick = 1;
                end else m_pc = m_pc + 1;
            end else begin
                if (!hold) m_mode = 1;
                else if (step && !m_stepq) begin
                    m_sel = scan_next(m_sel, mask); m_tick = 1;
                end
            end
            m_stepq = step;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs already driven; update model at the edge, compare 1ns later.
    task automatic cyc();
        bit m_active;
        @(posedge clk);
        model_edge();
        #1;
        m_active = (m_mode != 0);
        check("sel", {2'b00, sel}, 4'(m_sel));
        check("tick", {3'b000, tick}, {3'b000, m_tick});
        check("active", {3'b000, active}, {3'b000, m_active});
        check("en", {3'b000, en}, {3'b000, m_active & mask[m_sel[1:0]]});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int guard;
        reset_n = 1'b0; start = 0; stop = 0; hold = 0; step = 0; mask = 4'hF;

        // 1: reset
        cycles(2);
        check("rst_sel", {2'b00, sel}, 4'd0);
        check("rst_active", {3'b000, active}, 4'd0);
        reset_n = 1'b1;
        cycles(1);

        // 2: full mask scan
        mask = 4'hF; start = 1; cycles(1); start = 0;
        cycles(20);
        stop = 1; cycles(1); stop = 0;

        // 3: sparse mask, then empty mask start
        mask = 4'hA; start = 1; cycles(1); start = 0;
        cycles(16);
        stop = 1; cycles(1); stop = 0;
        mask = 4'h0; start = 1; cycles(3); start = 0;
        check("idle_empty_mask", {3'b000, active}, 4'd0);

        // 4: hold at prescaler 2, stepping
        mask = 4'hF; start = 1; cycles(1); start = 0;
        cycles(2);
        hold = 1; cycles(1);
        step = 1; cycles(3); step = 0; cycles(2);
        step = 1; cycles(1); step = 0; cycles(1);
        hold = 0; cycles(6);

        // 5: stop exactly on terminal count
        guard = 0;
        while (m_pc != DIV - 1 && guard < 10) begin cycles(1); guard++; end
        check("tc_reached", {3'b000, guard < 10}, 4'd1);
        stop = 1; cycles(1); stop = 0;
        check("stop_no_tick", {3'b000, tick}, 4'd0);
        cycles(2);

        // 6: reset mid-run with start asserted
        start = 1; cycles(1); start = 0; cycles(2);
        reset_n = 0; start = 1; cycles(1);
        check("rst_run_sel", {2'b00, sel}, 4'd0);
        reset_n = 1; start = 0; cycles(1);

        // mask edits while scanning
        mask = 4'h5; start = 1; cycles(1); start = 0; cycles(3);
        mask = 4'h0; cycles(9);
        mask = 4'h8; cycles(9);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 29) == 0);
            hold    = (i % 80 < 30) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            step    = $urandom_range(0, 1);
            if ($urandom_range(0, 24) == 0) mask = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
